// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: cell codes, board geometry, scan FSM states and walk directions.
// Used by win_scan_ctrl (optional diagonal scan enabled with macro WIN_SCAN_DIAG_EN).
package connect4_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P1    = 2'b01,
      P2    = 2'b10
   } cell_t;

   localparam int NUM_COLS = 7;
   localparam int NUM_ROWS = 6;
   localparam int MAX_STEP = 3;
   localparam int WIN_LEN  = 4;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EVAL,
      DONE
   } scan_state_t;

   typedef enum logic [1:0] {
      DIR_H,
      DIR_V,
      DIR_D1,
      DIR_D2
   } dir_t;

   function automatic cell_t player_cell(input logic player);
      return player ? P1 : P2;
   endfunction

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/win_scan_ctrl_if.sv
// Request/response and board-RAM read bundle of win_scan_ctrl.
// The controller takes the slave modport; the requester/RAM side takes master.
interface win_scan_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic [2:0]        col;
   logic [2:0]        row;
   logic              player;
   logic              rd_en;
   logic [ADDR_W-1:0] raddr;
   logic [1:0]        rdata;
   logic              busy;
   logic              done;
   logic              flag;

   modport master (
      output start, col, row, player, rdata,
      input  rd_en, raddr, busy, done, flag
   );

   modport slave (
      input  start, col, row, player, rdata,
      output rd_en, raddr, busy, done, flag
   );
endinterface

// File: rtl/c4_step_gen.sv
// Combinational walk target: (col,row) offset by sign*step along dir, packed as row*8+col.
// Diagonal offsets exist only when WIN_SCAN_DIAG_EN is defined.
module c4_step_gen
   import connect4_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic [2:0]        col_i,
   input  logic [2:0]        row_i,
   input  dir_t              dir_i,
   input  logic              sign_i,
   input  logic [2:0]        step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              in_bounds_o
);

   localparam logic signed [3:0] COLS_S = 4'(NUM_COLS);
   localparam logic signed [3:0] ROWS_S = 4'(NUM_ROWS);

   logic              col_move;
   logic              row_move;
   logic              row_neg;
   logic signed [3:0] off;
   logic signed [3:0] tgt_col;
   logic signed [3:0] tgt_row;
   logic [5:0]        cell_addr;

   // Past-the-edge targets wrap negative in 4-bit signed, so one bounds test covers both sides.
   always_comb begin
      col_move = 1'b0;
      row_move = 1'b0;
      row_neg  = 1'b0;
      case (dir_i)
         DIR_H: col_move = 1'b1;
         DIR_V: row_move = 1'b1;
`ifdef WIN_SCAN_DIAG_EN
         DIR_D1: begin
            col_move = 1'b1;
            row_move = 1'b1;
         end
         DIR_D2: begin
            col_move = 1'b1;
            row_move = 1'b1;
            row_neg  = 1'b1;
         end
`endif
         default: ;
      endcase
      off     = sign_i ? $signed({1'b0, step_i}) : -$signed({1'b0, step_i});
      tgt_col = $signed({1'b0, col_i}) + (col_move ? off : 4'sd0);
      tgt_row = $signed({1'b0, row_i}) + (row_move ? (row_neg ? -off : off) : 4'sd0);
   end

   assign in_bounds_o = (tgt_col >= 4'sd0) && (tgt_col < COLS_S) &&
                        (tgt_row >= 4'sd0) && (tgt_row < ROWS_S);
   assign cell_addr   = {tgt_row[2:0], tgt_col[2:0]};
   assign addr_o      = ADDR_W'(cell_addr);

endmodule

// File: rtl/win_scan_ctrl.sv
// Four-in-a-row scanner around the last dropped coin, reading the board RAM one cell at a time.
// Define WIN_SCAN_DIAG_EN to add the two diagonal directions to the H/V scan.
module win_scan_ctrl
   import connect4_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int MAX_CYC = 80
) (
   input logic            clk,
   input logic            rst,
   win_scan_ctrl_if.slave bus
);

`ifdef WIN_SCAN_DIAG_EN
   localparam dir_t LAST_DIR = DIR_D2;
   localparam int   NUM_DIRS = 4;
`else
   localparam dir_t LAST_DIR = DIR_V;
   localparam int   NUM_DIRS = 2;
`endif

   // Every read costs ISSUE+WAIT+EVAL; both sides of every direction, plus the DONE cycle.
   localparam int WORST_CYC = NUM_DIRS * 2 * MAX_STEP * 3 + 1;

   if (MAX_CYC < WORST_CYC) begin : g_max_cyc_check
      $error("win_scan_ctrl: MAX_CYC is below the worst-case scan latency");
   end

   scan_state_t       state_q, state_d;
   logic [2:0]        col_q, col_d;
   logic [2:0]        row_q, row_d;
   logic              player_q, player_d;
   dir_t              dir_q, dir_d;
   logic              sign_q, sign_d;
   logic [2:0]        step_q, step_d;
   logic [2:0]        count_q, count_d;
   cell_t             data_q, data_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              flag_q, flag_d;

   logic              side_end;
   logic [2:0]        count_inc;
   logic [2:0]        step_inc;
   logic [ADDR_W-1:0] tgt_addr;
   logic              tgt_inb;

   // Looks at the position the walk moves to, so rd_en/raddr are registered for that ISSUE cycle.
   c4_step_gen #(
      .ADDR_W (ADDR_W)
   ) u_step_gen (
      .col_i       (col_d),
      .row_i       (row_d),
      .dir_i       (dir_d),
      .sign_i      (sign_d),
      .step_i      (step_d),
      .addr_o      (tgt_addr),
      .in_bounds_o (tgt_inb)
   );

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      player_d  = player_q;
      dir_d     = dir_q;
      sign_d    = sign_q;
      step_d    = step_q;
      count_d   = count_q;
      data_d    = data_q;
      flag_d    = flag_q;
      side_end  = 1'b0;
      count_inc = sat_inc3(count_q);
      step_inc  = step_q + 3'd1;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               col_d    = bus.col;
               row_d    = bus.row;
               player_d = bus.player;
               dir_d    = DIR_H;
               sign_d   = 1'b0;
               step_d   = 3'd1;
               count_d  = 3'd1;
               flag_d   = 1'b0;
               state_d  = (bus.col >= 3'(NUM_COLS) || bus.row >= 3'(NUM_ROWS)) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (rd_en_q) state_d = WAIT;
            else         side_end = 1'b1;
         end
         WAIT: begin
            data_d  = cell_t'(bus.rdata);
            state_d = EVAL;
         end
         EVAL: begin
            if (data_q == player_cell(player_q)) begin
               count_d = count_inc;
               step_d  = step_inc;
               if (count_inc == 3'(WIN_LEN)) begin
                  flag_d  = 1'b1;
                  state_d = DONE;
               end else if (step_inc > 3'(MAX_STEP)) begin
                  side_end = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end else begin
               side_end = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Negative side first, then positive side, then the next direction.
      if (side_end) begin
         step_d = 3'd1;
         if (!sign_q) begin
            sign_d  = 1'b1;
            state_d = ISSUE;
         end else if (dir_q == LAST_DIR) begin
            flag_d  = 1'b0;
            state_d = DONE;
         end else begin
            dir_d   = dir_t'(dir_q + 2'd1);
            sign_d  = 1'b0;
            count_d = 3'd1;
            state_d = ISSUE;
         end
      end
   end

   always_comb begin
      rd_en_d = (state_d == ISSUE) && tgt_inb;
      raddr_d = rd_en_d ? tgt_addr : raddr_q;
      busy_d  = (state_d == ISSUE) || (state_d == WAIT) || (state_d == EVAL);
      done_d  = (state_d == DONE);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         player_q <= 1'b0;
         dir_q    <= DIR_H;
         sign_q   <= 1'b0;
         step_q   <= 3'd1;
         count_q  <= 3'd1;
         data_q   <= EMPTY;
         rd_en_q  <= 1'b0;
         raddr_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         player_q <= player_d;
         dir_q    <= dir_d;
         sign_q   <= sign_d;
         step_q   <= step_d;
         count_q  <= count_d;
         data_q   <= data_d;
         rd_en_q  <= rd_en_d;
         raddr_q  <= raddr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         flag_q   <= flag_d;
      end
   end

   assign bus.rd_en = rd_en_q;
   assign bus.raddr = raddr_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.flag  = flag_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Self-checking bench for win_scan_ctrl: directed win/no-win boards, reset cases and random boards
// checked against a loop-based reference walk (diagonals follow WIN_SCAN_DIAG_EN).
module tb_win_scan_ctrl;
   import connect4_pkg::*;

   localparam int ADDR_W  = 6;
   localparam int MAX_CYC = 80;
`ifdef WIN_SCAN_DIAG_EN
   localparam int N_DIRS  = 4;
   localparam bit DIAG_ON = 1'b1;
`else
   localparam int N_DIRS  = 2;
   localparam bit DIAG_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   win_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   win_scan_ctrl #(
      .ADDR_W  (ADDR_W),
      .MAX_CYC (MAX_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [1:0] board [64];
   int         n_checks = 0;
   int         n_fails  = 0;
   int         got_reads[$];
   int         exp_reads[$];
   bit         exp_flag;
   bit         last_flag;
   int         last_cyc;

   // Board RAM: data appears the cycle after the read strobe.
   always @(posedge clk) if (bus.rd_en) bus.rdata <= board[bus.raddr];

   always @(negedge clk) if (bus.rd_en) got_reads.push_back(int'(bus.raddr));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_board();
      for (int i = 0; i < 64; i++) board[i] = EMPTY;
   endtask

   task automatic place(input int c, input int r, input cell_t code);
      board[r * 8 + c] = code;
   endtask

   // Walk each direction outward from the coin, negative side then positive side, up to 3 cells.
   task automatic model_scan(input int c, input int r, input bit p);
      int dcs[4]   = '{1, 0, 1, 1};
      int drs[4]   = '{0, 1, 1, -1};
      int sides[2] = '{-1, 1};
      int code;
      int run;
      int tc;
      int tr;
      bit stop;
      exp_reads.delete();
      exp_flag = 1'b0;
      if (c > 6 || r > 5) return;
      code = p ? 1 : 2;
      for (int d = 0; d < N_DIRS; d++) begin
         run = 1;
         for (int sd = 0; sd < 2; sd++) begin
            stop = 1'b0;
            for (int s = 1; s <= 3 && !stop; s++) begin
               tc = c + sides[sd] * s * dcs[d];
               tr = r + sides[sd] * s * drs[d];
               if (tc < 0 || tc > 6 || tr < 0 || tr > 5) begin
                  stop = 1'b1;
               end else begin
                  exp_reads.push_back(tr * 8 + tc);
                  if (int'(board[tr * 8 + tc]) != code) begin
                     stop = 1'b1;
                  end else begin
                     run++;
                     if (run >= 4) begin
                        exp_flag = 1'b1;
                        return;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic pulse_rst_check(input string tag);
      #1 rst = 1'b1;
      #1;
      check({tag, "_rd_en"}, bus.rd_en, 1'b0);
      check({tag, "_raddr"}, bus.raddr, '0);
      check({tag, "_busy"},  bus.busy,  1'b0);
      check({tag, "_done"},  bus.done,  1'b0);
      check({tag, "_flag"},  bus.flag,  1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_scan(input int c, input int r, input bit p,
                          input bit inj_busy, input bit inj_done, input string tag);
      int  cyc;
      bit  seen;
      int  n;
      model_scan(c, r, p);
      got_reads.delete();
      @(negedge clk);
      bus.start  = 1'b1;
      bus.col    = 3'(c);
      bus.row    = 3'(r);
      bus.player = p;
      @(negedge clk);
      bus.start = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc <= MAX_CYC + 4) begin
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (inj_busy && cyc == 2) begin
               bus.start  = 1'b1;
               bus.col    = 3'd0;
               bus.row    = 3'd0;
               bus.player = ~p;
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      bus.start = 1'b0;
      last_flag = bus.flag;
      last_cyc  = cyc;
      check($sformatf("%s_done_seen", tag), seen, 1'b1);
      check($sformatf("%s_latency_ok", tag), cyc <= MAX_CYC, 1'b1);
      check($sformatf("%s_flag", tag), bus.flag, exp_flag);
      check($sformatf("%s_nreads", tag), got_reads.size(), exp_reads.size());
      n = (got_reads.size() < exp_reads.size()) ? got_reads.size() : exp_reads.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_raddr%0d", tag, i), got_reads[i], exp_reads[i]);
      foreach (got_reads[i])
         check($sformatf("%s_inbounds%0d", tag, i),
               (got_reads[i] % 8) <= 6 && (got_reads[i] / 8) <= 5, 1'b1);
      if (inj_done) begin
         bus.start  = 1'b1;
         bus.col    = 3'd3;
         bus.row    = 3'd2;
         bus.player = ~p;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("%s_flag_held", tag), bus.flag, exp_flag);
      check($sformatf("%s_idle_after", tag), {bus.busy, bus.done}, 2'b00);
   endtask

   initial begin
      int c;
      int r;
      int k;
      int wait_n;
      bit p;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.col    = 3'd0;
      bus.row    = 3'd0;
      bus.player = 1'b0;
      clear_board();
      repeat (3) @(negedge clk);
      check("rst_rd_en", bus.rd_en, 1'b0);
      check("rst_raddr", bus.raddr, '0);
      check("rst_busy",  bus.busy,  1'b0);
      check("rst_done",  bus.done,  1'b0);
      check("rst_flag",  bus.flag,  1'b0);
      rst = 1'b0;

      // Horizontal P1 win along the bottom row
      clear_board();
      for (int i = 0; i < 4; i++) place(i, 0, P1);
      do_scan(3, 0, 1'b1, 1'b0, 1'b0, "h_win");
      check("h_win_const", last_flag, 1'b1);
      pulse_rst_check("rst_clears_flag");

      // Vertical P2 win: H reads (3,3),(5,3), then V down (4,2),(4,1),(4,0)
      clear_board();
      for (int i = 0; i < 4; i++) place(4, i, P2);
      do_scan(4, 3, 1'b0, 1'b0, 1'b0, "v_win");
      check("v_win_const", last_flag, 1'b1);
      check("v_win_nreads_const", got_reads.size(), 5);

      // Diagonal only counts when the diagonal scan is built in
      clear_board();
      for (int i = 0; i < 4; i++) place(i, i, P1);
      do_scan(1, 1, 1'b1, 1'b0, 1'b0, "d1_win");
      check("d1_win_const", last_flag, DIAG_ON);

      // Lone corner coin
      clear_board();
      place(6, 5, P1);
      do_scan(6, 5, 1'b1, 1'b0, 1'b0, "corner");
      check("corner_const", last_flag, 1'b0);

      // Out-of-range requests finish immediately without reads
      do_scan(7, 0, 1'b1, 1'b0, 1'b0, "col7");
      check("col7_latency", last_cyc, 1);
      check("col7_no_reads", got_reads.size(), 0);
      do_scan(2, 6, 1'b0, 1'b0, 1'b0, "row6");
      check("row6_latency", last_cyc, 1);

      // Reset in WAIT, then a normal scan
      clear_board();
      @(negedge clk);
      bus.start  = 1'b1;
      bus.col    = 3'd3;
      bus.row    = 3'd2;
      bus.player = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_n = 0;
      while (!bus.rd_en && wait_n < 8) begin
         @(negedge clk);
         wait_n++;
      end
      check("wait_rd_seen", bus.rd_en, 1'b1);
      @(negedge clk);
      check("wait_busy",   bus.busy,  1'b1);
      check("wait_rd_low", bus.rd_en, 1'b0);
      check("wait_raddr",  bus.raddr, 18);
      pulse_rst_check("rst_in_wait");
      place(2, 2, P1);
      place(4, 2, P1);
      place(5, 2, P1);
      do_scan(3, 2, 1'b1, 1'b0, 1'b0, "after_rst");
      check("after_rst_const", last_flag, 1'b1);

      // Starts while busy and in DONE must be ignored
      clear_board();
      for (int i = 0; i < 4; i++) place(i, 0, P1);
      do_scan(3, 0, 1'b1, 1'b1, 1'b1, "ignore_start");
      check("ignore_start_const", last_flag, 1'b1);

      // Random boards
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 64; i++) begin
            k = $urandom_range(0, 9);
            board[i] = (k < 4) ? P1 : (k < 8) ? P2 : EMPTY;
         end
         c = $urandom_range(0, 6);
         r = $urandom_range(0, 5);
         p = 1'($urandom_range(0, 1));
         place(c, r, p ? P1 : P2);
         if ($urandom_range(0, 9) == 0) c = 7;
         do_scan(c, r, p, c != 7 && $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $sformatf("rnd%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/win_scan_ctrl.md
WIN_SCAN_CTRL -- requirements
Module: win_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: board RAM address width, with cell address = row*8 + col.
REQ-002 The block SHALL have parameter MAX_CYC, default 80: documented worst-case scan latency, used by the bench only.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to scan around the last dropped coin.
REQ-006 col  in  3  column of the last coin (0-6 valid).
REQ-007 row  in  3  row of the last coin (0 = bottom, 0-5 valid).
REQ-008 player  in  1  mover of the last coin (1 = 1st player, cell code 2'b01; 0 = 2nd player, cell code 2'b10).
REQ-009 rd_en  out  1  board RAM read strobe.
REQ-010 raddr  out  ADDR_W  board RAM read address.
REQ-011 rdata  in  2  board RAM data, valid exactly 1 cycle after rd_en.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 flag  out  1  four-in-a-row found; valid with done and held until the next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, EVAL, DONE.
REQ-016 IDLE + start: latch col/row/player; dir = H; sign = negative; step = 1; count = 1; go to ISSUE.
REQ-017 start while busy or in DONE SHALL be ignored.
REQ-018 start with col = 7 or row > 5: go directly to DONE with flag = 0, no reads issued.
REQ-019 Directions SHALL be H (dc=1, dr=0), V (dc=0, dr=1), D1 (1,1) and D2 (1,-1), scanned in that order; the target is (col + sign*step*dc, row + sign*step*dr).
REQ-020 Target out of bounds (col outside 0-6 or row outside 0-5), in ISSUE: treat as mismatch without a read and advance the walk in the same cycle.
REQ-021 Target in bounds, in ISSUE: rd_en = 1 and raddr = target for one cycle, then WAIT, then EVAL.
REQ-022 EVAL, rdata equals the player code: count += 1, step += 1.
REQ-023 Reaching count = 4 SHALL go to DONE with flag = 1, ending the scan early.
REQ-024 Mismatch or step > 3, with sign negative: switch to sign positive, step = 1.
REQ-025 Mismatch or step > 3, with sign positive: go to the next direction, count = 1.
REQ-026 Exhausting the last direction SHALL go to DONE with flag = 0.
REQ-027 count SHALL be 3 bits, saturating; the coordinate arithmetic SHALL be 4-bit signed.
REQ-028 DONE: done = 1 for exactly one cycle, then return to IDLE; worst-case start-to-done is at most MAX_CYC cycles.
REQ-029 rd_en SHALL be 0 in every state except ISSUE.

Reset
REQ-030 rst asserted at any time, including mid-scan, SHALL force IDLE with rd_en = 0, raddr = 0, busy = 0, done = 0, flag = 0, count = 1 and step = 1.
REQ-031 The first accepted start after rst deassertion SHALL scan normally.

Configuration
REQ-032 Macro WIN_SCAN_DIAG_EN defined: all four directions are scanned.
REQ-033 Macro WIN_SCAN_DIAG_EN undefined: only H and V are scanned, and DONE follows V; the D1/D2 logic is not compiled.

Structure
REQ-034 Package connect4_pkg SHALL hold the cell_t enum (EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10), NUM_COLS = 7, NUM_ROWS = 6, the scan_state_t enum and the dir_t enum.
REQ-035 Sub-module c4_step_gen SHALL be combinational: latched coordinates, dir, sign and step in -> target address and in_bounds out.

Verification
REQ-036 P1 coins at (0,0),(1,0),(2,0),(3,0), start col=3 row=0 player=1 -> done within 80 cycles, flag = 1.
REQ-037 P2 coins at (4,0)-(4,3), start col=4 row=3 player=0 -> flag = 1 after the V scan; no D1/D2 reads issued.
REQ-038 WIN_SCAN_DIAG_EN defined, P1 coins at (0,0),(1,1),(2,2),(3,3), start col=1 row=1 -> flag = 1; with the macro undefined the same stimulus -> flag = 0.
REQ-039 Empty board except a P1 coin at (6,5), start col=6 row=5 -> flag = 0, and every raddr issued is in bounds.
REQ-040 rst pulsed during WAIT -> all outputs return to reset values immediately (asynchronously); a new start then completes normally.
REQ-041 start col = 7 -> done the next cycle, flag = 0, rd_en never asserted.
